alarm_bank: RTL and testbench
=============================

# alarm_bank

Parametrised multi-alarm unit for the digital clock: holds `N_ALARMS` independently settable and armable BCD alarm times. Each second it compares them against the running time-of-day. It runs a ring/snooze/stop state machine with auto-timeout and a snooze limit. It sits between the time-of-day register and the piezo sequencer, replacing the single fixed alarm and its combinational match.

## Interface
- `N_ALARMS`, 4, number of alarm slots (1..8)
- `SNOOZE_MIN`, 9, minute boundaries counted before a snoozed alarm re-rings (1..59)
- `MAX_SNOOZE`, 3, snoozes allowed per ring episode; the next snooze acts as stop
- `RING_SEC`, 60, seconds of ringing before auto-stop (1..255)
- `clk` in 1: 50MHz system clock
- `rst` in 1: one clock; reset is synchronous and active-high
- `tick_sec` in 1: one-cycle pulse in the cycle the time digits present a new second
- `hours10`, `hours`, `minutes10`, `minutes`, `seconds10`, `seconds` in 4 each: current BCD time, 24h
- `sel` in $clog2(N_ALARMS): alarm slot targeted by increments and display
- `inc_min`, `inc_min10`, `inc_hr`, `inc_hr10` in 1 each: one-cycle increment pulses for slot `sel`
- `arm` in N_ALARMS: level enable per slot
- `snooze` in 1: one-cycle pulse
- `stop` in 1: one-cycle pulse
- `dsp_hours10`, `dsp_hours`, `dsp_minutes10`, `dsp_minutes` out 4 each: stored time of slot `sel`, combinational
- `alarm_start` out 1: one-cycle pulse when ringing begins (first ring or snooze re-ring)
- `ringing` out 1: level, high in RING
- `ring_idx` out $clog2(N_ALARMS): slot owning the current episode
- `snooze_cnt` out $clog2(MAX_SNOOZE+1): snoozes used in the current episode

## Operation
- Alarm slots: BCD HH:MM, all reset to 00:00.
- Increment rules have no carry between digits:
  - `inc_min`: 0..9 wrap.
  - `inc_min10`: 0..5 wrap.
  - `inc_hr`: 0..9 wrap, or 0..3 wrap when hours10==2.
  - `inc_hr10`: 0..2 wrap; entering 2 with hours>3 forces hours to 0.
- Multiple increment pulses in one cycle are all applied. A `sel` out of range is ignored.
- Match for slot i: `tick_sec` & seconds10==0 & seconds==0 & HH:MM equal & arm[i].
- If several slots match, the lowest index wins.
- Minute boundary: `tick_sec` with seconds10==0 and seconds==0.
- States:
  - IDLE: on match, go to RING; latch ring_idx, clear snooze_cnt, load ring timer = RING_SEC, pulse alarm_start.
  - RING: `stop` goes to IDLE. `snooze` with snooze_cnt<MAX_SNOOZE goes to SNOOZE, increments snooze_cnt and loads the minute counter = SNOOZE_MIN. `snooze` with snooze_cnt==MAX_SNOOZE goes to IDLE. The ring timer decrements on `tick_sec`; reaching 0 goes to IDLE.
  - SNOOZE: each minute boundary decrements the minute counter. Reaching 0 goes to RING, reloads the ring timer and pulses alarm_start. `stop` goes to IDLE.
- Matches arriving in RING or SNOOZE are dropped, including other slots.
- Any state: arm[ring_idx] deasserted goes to IDLE next cycle.
- `stop` and `snooze` in the same cycle: stop wins.
- Editing slot ring_idx during an episode does not affect the snooze re-ring.
- Reset values: state IDLE, alarm_start 0, ringing 0, ring_idx 0, snooze_cnt 0, all slots 00:00. `rst` mid-episode returns to IDLE and clears the slots.

## Timing
- Match detection is registered:
  - `tick_sec` in cycle T gives alarm_start=1 and ringing=1 in cycle T+1.
  - alarm_start is high for exactly one cycle.
- `stop`/`snooze` in cycle T: ringing=0 in T+1.
- Increment pulse in cycle T: slot updated and visible on dsp_* in T+1.
- Snooze re-ring: alarm_start in the cycle after the SNOOZE_MIN-th minute boundary following the snooze.
- Auto-stop: ringing falls the cycle after the RING_SEC-th `tick_sec` after entry.
- Inputs are synchronous to clk. No handshakes; pulses must be single-cycle.

## Structure
- Shared package `clock_pkg`:
  - `bcd_t` (logic [3:0]).
  - `hhmm_t` struct {hours10, hours, minutes10, minutes}.
  - State enum `alrm_state_t` {IDLE, RING, SNOOZE}.
  - Digit limit constants.
- Sub-module `alarm_slot`: one BCD HH:MM register with the increment/clamp rules and an equality compare output. Instantiate N_ALARMS copies with a generate loop.
- Priority encoder, timers and FSM live in `alarm_bank`.

## Test plan
- Set slot 1 to 07:30 (7×`inc_hr`, 3×`inc_min10`), arm=4'b0010. Drive time to 07:30:00 with `tick_sec` -> alarm_start 1 cycle later, ring_idx=1, ringing=1.
- Slots 0 and 2 both at 06:00, both armed -> ring_idx=0. Slot 2 does not ring after `stop`.
- SNOOZE_MIN=9: ring, then `snooze` -> ringing=0, snooze_cnt=1. After 9 minute boundaries -> alarm_start again. The 4th `snooze` (MAX_SNOOZE=3) -> IDLE.
- RING_SEC=60, no input -> ringing drops after the 60th `tick_sec`. `stop` and `snooze` in the same cycle -> IDLE, snooze_cnt unchanged.
- Slot at 1:9 (hours10=1, hours=9), then `inc_hr10` -> 2:0. 3×`inc_hr` at hours10=2 -> wraps 3 to 0. `inc_min10` from 5 -> 0.
- Ringing, then deassert arm[ring_idx] -> IDLE next cycle. Assert `rst` in SNOOZE -> all outputs reset values next cycle.

Source files
------------

// File: rtl/clock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : clock_pkg                                                    |
// | Description : Shared types and digit limits for the digital clock blocks:  |
// |               BCD digit type, HH:MM struct, alarm FSM states and a wrap   |
// |               increment helper.                                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t hours10;
    bcd_t hours;
    bcd_t minutes10;
    bcd_t minutes;
  } hhmm_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alrm_state_t;

  localparam bcd_t MIN_MAX   = 4'd9;
  localparam bcd_t MIN10_MAX = 4'd5;
  localparam bcd_t HR_MAX    = 4'd9;
  localparam bcd_t HR_MAX_HI = 4'd3;  // hours digit limit once hours10 is 2
  localparam bcd_t HR10_MAX  = 4'd2;

  // Increment a digit, wrapping to 0 once the limit is reached.
  function automatic bcd_t bcd_wrap_inc(input bcd_t v, input bcd_t lim);
    return (v >= lim) ? 4'd0 : v + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_bank_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : alarm_bank_if                                                |
// | Description : Signal bundle between the time-of-day/user-input side        |
// |               (master) and the alarm bank (slave).                         |
// |   master drives: tick_sec, current BCD time, sel, inc_*, arm, snooze, stop |
// |   slave drives : dsp_* (selected slot), alarm_start, ringing, ring_idx,    |
// |                  snooze_cnt                                                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface alarm_bank_if #(
  parameter int N_ALARMS   = 4,
  parameter int MAX_SNOOZE = 3
);
  import clock_pkg::*;

  localparam int SEL_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
  localparam int CNT_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  logic                tick_sec;
  bcd_t                hours10, hours, minutes10, minutes, seconds10, seconds;
  logic [SEL_W-1:0]    sel;
  logic                inc_min, inc_min10, inc_hr, inc_hr10;
  logic [N_ALARMS-1:0] arm;
  logic                snooze;
  logic                stop;
  bcd_t                dsp_hours10, dsp_hours, dsp_minutes10, dsp_minutes;
  logic                alarm_start;
  logic                ringing;
  logic [SEL_W-1:0]    ring_idx;
  logic [CNT_W-1:0]    snooze_cnt;

  modport master (
    output tick_sec, hours10, hours, minutes10, minutes, seconds10, seconds,
    output sel, inc_min, inc_min10, inc_hr, inc_hr10, arm, snooze, stop,
    input  dsp_hours10, dsp_hours, dsp_minutes10, dsp_minutes,
    input  alarm_start, ringing, ring_idx, snooze_cnt
  );

  modport slave (
    input  tick_sec, hours10, hours, minutes10, minutes, seconds10, seconds,
    input  sel, inc_min, inc_min10, inc_hr, inc_hr10, arm, snooze, stop,
    output dsp_hours10, dsp_hours, dsp_minutes10, dsp_minutes,
    output alarm_start, ringing, ring_idx, snooze_cnt
  );

endinterface
`default_nettype wire

// File: rtl/alarm_slot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alarm_slot                                                   |
// | Description : One BCD HH:MM alarm register with carry-free digit          |
// |               increments and an equality compare against the current time.|
// |   clk, rst      : clock, synchronous active-high reset (slot -> 00:00)     |
// |   inc_*_i       : one-cycle increment pulses (all applied together)        |
// |   now_i         : current HH:MM                                            |
// |   time_o        : stored HH:MM                                             |
// |   eq_o          : stored HH:MM equals now_i                                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module alarm_slot
  import clock_pkg::*;
(
  input  wire logic  clk,
  input  wire logic  rst,
  input  wire logic  inc_min_i,
  input  wire logic  inc_min10_i,
  input  wire logic  inc_hr_i,
  input  wire logic  inc_hr10_i,
  input  wire hhmm_t now_i,
  output hhmm_t      time_o,
  output logic       eq_o
);

  hhmm_t slot_q, slot_d;
  bcd_t  hr_lim;
  bcd_t  hr_next;

  always_comb begin
    slot_d  = slot_q;
    hr_lim  = (slot_q.hours10 == HR10_MAX) ? HR_MAX_HI : HR_MAX;
    hr_next = inc_hr_i ? bcd_wrap_inc(slot_q.hours, hr_lim) : slot_q.hours;

    if (inc_min_i)   slot_d.minutes   = bcd_wrap_inc(slot_q.minutes, MIN_MAX);
    if (inc_min10_i) slot_d.minutes10 = bcd_wrap_inc(slot_q.minutes10, MIN10_MAX);
    if (inc_hr10_i)  slot_d.hours10   = bcd_wrap_inc(slot_q.hours10, HR10_MAX);
    slot_d.hours = hr_next;
    // Moving into the 20s must never leave an illegal 24..29 hour.
    if (inc_hr10_i && (slot_d.hours10 == HR10_MAX) && (hr_next > HR_MAX_HI))
      slot_d.hours = 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

  assign time_o = slot_q;
  assign eq_o   = (slot_q == now_i);

endmodule
`default_nettype wire

// File: rtl/alarm_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alarm_bank                                                   |
// | Description : N_ALARMS armable BCD alarm slots, lowest-index priority     |
// |               match on minute boundaries, and a ring/snooze/stop FSM with |
// |               ring auto-timeout and a per-episode snooze limit.           |
// |   clk, rst : 50 MHz clock, synchronous active-high reset                   |
// |   bus      : alarm_bank_if slave (time, edit pulses, arm, snooze/stop in; |
// |              selected-slot display, alarm_start, ringing, ring_idx,       |
// |              snooze_cnt out)                                              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module alarm_bank
  import clock_pkg::*;
#(
  parameter int N_ALARMS   = 4,
  parameter int SNOOZE_MIN = 9,
  parameter int MAX_SNOOZE = 3,
  parameter int RING_SEC   = 60
) (
  input wire logic    clk,
  input wire logic    rst,
  alarm_bank_if.slave bus
);

  localparam int SEL_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
  localparam int CNT_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  hhmm_t               now;
  logic                min_bnd;
  hhmm_t               slot_time [N_ALARMS];
  logic [N_ALARMS-1:0] slot_eq;
  logic [N_ALARMS-1:0] match;
  logic                hit;
  logic [SEL_W-1:0]    hit_idx;
  hhmm_t               dsp;

  alrm_state_t      state_q, state_d;
  logic [SEL_W-1:0] ring_idx_q, ring_idx_d;
  logic [CNT_W-1:0] snooze_cnt_q, snooze_cnt_d;
  logic [7:0]       ring_tmr_q, ring_tmr_d;
  logic [5:0]       min_cnt_q, min_cnt_d;
  logic             alarm_start_q, alarm_start_d;

  assign now     = '{hours10: bus.hours10, hours: bus.hours,
                     minutes10: bus.minutes10, minutes: bus.minutes};
  assign min_bnd = bus.tick_sec && (bus.seconds10 == 4'd0) && (bus.seconds == 4'd0);

  // An out-of-range sel matches no slot, so its edits are dropped.
  for (genvar i = 0; i < N_ALARMS; i++) begin : g_slot
    alarm_slot u_slot (
      .clk         (clk),
      .rst         (rst),
      .inc_min_i   (bus.inc_min   && (bus.sel == SEL_W'(i))),
      .inc_min10_i (bus.inc_min10 && (bus.sel == SEL_W'(i))),
      .inc_hr_i    (bus.inc_hr    && (bus.sel == SEL_W'(i))),
      .inc_hr10_i  (bus.inc_hr10  && (bus.sel == SEL_W'(i))),
      .now_i       (now),
      .time_o      (slot_time[i]),
      .eq_o        (slot_eq[i])
    );
  end

  assign match = slot_eq & bus.arm & {N_ALARMS{min_bnd}};
  assign hit   = |match;

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    hit_idx = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--)
      if (match[i]) hit_idx = SEL_W'(i);
  end

  always_comb begin
    dsp = '0;
    for (int i = 0; i < N_ALARMS; i++)
      if (bus.sel == SEL_W'(i)) dsp = slot_time[i];
  end

  always_comb begin
    state_d       = state_q;
    ring_idx_d    = ring_idx_q;
    snooze_cnt_d  = snooze_cnt_q;
    ring_tmr_d    = ring_tmr_q;
    min_cnt_d     = min_cnt_q;
    alarm_start_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hit) begin
          state_d       = RING;
          ring_idx_d    = hit_idx;
          snooze_cnt_d  = '0;
          ring_tmr_d    = 8'(RING_SEC);
          alarm_start_d = 1'b1;
        end
      end
      RING: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.snooze) begin
          if (snooze_cnt_q < CNT_W'(MAX_SNOOZE)) begin
            state_d      = SNOOZE;
            snooze_cnt_d = snooze_cnt_q + 1'b1;
            min_cnt_d    = 6'(SNOOZE_MIN);
          end else begin
            state_d = IDLE;  // snooze budget spent: acts as stop
          end
        end else if (bus.tick_sec) begin
          ring_tmr_d = ring_tmr_q - 8'd1;
          if (ring_tmr_d == 8'd0) state_d = IDLE;
        end
      end
      SNOOZE: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (min_bnd) begin
          min_cnt_d = min_cnt_q - 6'd1;
          if (min_cnt_d == 6'd0) begin
            state_d       = RING;
            ring_tmr_d    = 8'(RING_SEC);
            alarm_start_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Disarming the owning slot ends the episode from any active state.
    if ((state_q != IDLE) && !bus.arm[ring_idx_q]) begin
      state_d       = IDLE;
      alarm_start_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ring_idx_q    <= '0;
      snooze_cnt_q  <= '0;
      ring_tmr_q    <= '0;
      min_cnt_q     <= '0;
      alarm_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ring_idx_q    <= ring_idx_d;
      snooze_cnt_q  <= snooze_cnt_d;
      ring_tmr_q    <= ring_tmr_d;
      min_cnt_q     <= min_cnt_d;
      alarm_start_q <= alarm_start_d;
    end
  end

  assign bus.dsp_hours10   = dsp.hours10;
  assign bus.dsp_hours     = dsp.hours;
  assign bus.dsp_minutes10 = dsp.minutes10;
  assign bus.dsp_minutes   = dsp.minutes;
  assign bus.alarm_start   = alarm_start_q;
  assign bus.ringing       = (state_q == RING);
  assign bus.ring_idx      = ring_idx_q;
  assign bus.snooze_cnt    = snooze_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alarm_bank                                                |
// | Description : Directed self-checking bench for alarm_bank (4 slots,       |
// |               SNOOZE_MIN=9, MAX_SNOOZE=3, RING_SEC=60).                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_alarm_bank;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alarm_bank_if #(.N_ALARMS(4), .MAX_SNOOZE(3)) bus ();

  alarm_bank #(
    .N_ALARMS(4), .SNOOZE_MIN(9), .MAX_SNOOZE(3), .RING_SEC(60)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] dsp();
    return {bus.dsp_hours10, bus.dsp_hours, bus.dsp_minutes10, bus.dsp_minutes};
  endfunction

  // kind: 0 inc_min, 1 inc_min10, 2 inc_hr, 3 inc_hr10
  task automatic inc(input int slot, input int kind, input int n);
    for (int k = 0; k < n; k++) begin
      bus.sel       = 2'(slot);
      bus.inc_min   = (kind == 0);
      bus.inc_min10 = (kind == 1);
      bus.inc_hr    = (kind == 2);
      bus.inc_hr10  = (kind == 3);
      cyc();
      bus.inc_min = 0; bus.inc_min10 = 0; bus.inc_hr = 0; bus.inc_hr10 = 0;
    end
  endtask

  task automatic set_time(input logic [3:0] h10, h, m10, m, s10, s);
    bus.hours10 = h10; bus.hours = h; bus.minutes10 = m10;
    bus.minutes = m;   bus.seconds10 = s10; bus.seconds = s;
  endtask

  task automatic tick_at(input logic [3:0] h10, h, m10, m, s10, s);
    set_time(h10, h, m10, m, s10, s);
    bus.tick_sec = 1'b1;
    cyc();
    bus.tick_sec = 1'b0;
  endtask

  // n back-to-back minute boundaries at 12:00:00 (no slot is set to 12:00)
  task automatic boundaries(input int n);
    set_time(1, 2, 0, 0, 0, 0);
    for (int k = 0; k < n; k++) begin
      bus.tick_sec = 1'b1;
      cyc();
    end
    bus.tick_sec = 1'b0;
  endtask

  task automatic pulse(input logic do_snooze, input logic do_stop);
    bus.snooze = do_snooze;
    bus.stop   = do_stop;
    cyc();
    bus.snooze = 1'b0;
    bus.stop   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.tick_sec = 0; bus.sel = 0; bus.arm = '0;
    bus.inc_min = 0; bus.inc_min10 = 0; bus.inc_hr = 0; bus.inc_hr10 = 0;
    bus.snooze = 0; bus.stop = 0;
    set_time(0, 0, 0, 0, 0, 1);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Reset state
    chk("rst_alarm_start", bus.alarm_start, 0);
    chk("rst_ringing",     bus.ringing,     0);
    chk("rst_ring_idx",    bus.ring_idx,    0);
    chk("rst_snooze_cnt",  bus.snooze_cnt,  0);
    chk("rst_dsp0",        dsp(),           16'h0000);

    // Slot 1 -> 07:30, single match
    inc(1, 2, 7);
    inc(1, 1, 3);
    chk("slot1_0730", dsp(), 16'h0730);
    bus.arm = 4'b0010;
    tick_at(0, 7, 3, 1, 0, 0);
    chk("no_ring_0731", bus.ringing, 0);
    set_time(0, 7, 3, 0, 0, 0);
    cyc();
    chk("no_ring_without_tick", bus.ringing, 0);
    tick_at(0, 7, 3, 0, 0, 0);
    chk("m1_alarm_start", bus.alarm_start, 1);
    chk("m1_ringing",     bus.ringing,     1);
    chk("m1_ring_idx",    bus.ring_idx,    1);
    cyc();
    chk("m1_start_one_cycle", bus.alarm_start, 0);
    chk("m1_still_ringing",   bus.ringing,     1);
    pulse(0, 1);
    chk("m1_stop", bus.ringing, 0);

    // Slots 0 and 2 at 06:00 -> slot 0 wins, slot 2 silent after stop
    inc(0, 2, 6);
    inc(2, 2, 6);
    bus.arm = 4'b0101;
    tick_at(0, 6, 0, 0, 0, 0);
    chk("prio_ringing", bus.ringing,  1);
    chk("prio_idx",     bus.ring_idx, 0);
    pulse(0, 1);
    chk("prio_stop", bus.ringing, 0);
    cyc();
    chk("prio_no_slot2_start", bus.alarm_start, 0);
    chk("prio_no_slot2_ring",  bus.ringing,     0);

    // Snooze cycling up to the limit
    bus.arm = 4'b0001;
    tick_at(0, 6, 0, 0, 0, 0);
    chk("sn_ring", bus.ringing, 1);
    for (int k = 1; k <= 3; k++) begin
      pulse(1, 0);
      chk("sn_ringing_off", bus.ringing, 0);
      chk("sn_cnt", bus.snooze_cnt, k);
      tick_at(1, 2, 0, 0, 0, 1);  // not a minute boundary
      boundaries(8);
      chk("sn_no_early_start", bus.alarm_start, 0);
      chk("sn_no_early_ring",  bus.ringing,     0);
      boundaries(1);
      chk("sn_rering_start", bus.alarm_start, 1);
      chk("sn_rering_ring",  bus.ringing,     1);
    end
    pulse(1, 0);
    chk("sn4_off", bus.ringing,    0);
    chk("sn4_cnt", bus.snooze_cnt, 3);
    boundaries(9);
    chk("sn4_idle_no_start", bus.alarm_start, 0);
    chk("sn4_idle_no_ring",  bus.ringing,     0);

    // Ring auto-timeout after 60 ticks
    tick_at(0, 6, 0, 0, 0, 0);
    chk("to_ring", bus.ringing,    1);
    chk("to_cnt0", bus.snooze_cnt, 0);
    set_time(0, 6, 0, 0, 0, 1);
    bus.tick_sec = 1'b1;
    for (int k = 0; k < 59; k++) cyc();
    bus.tick_sec = 1'b0;
    chk("to_after59", bus.ringing, 1);
    tick_at(0, 6, 0, 0, 0, 1);
    chk("to_after60", bus.ringing, 0);

    // stop and snooze together: stop wins
    tick_at(0, 6, 0, 0, 0, 0);
    pulse(1, 0);
    boundaries(9);
    chk("ss_rering", bus.ringing, 1);
    pulse(1, 1);
    chk("ss_off", bus.ringing,    0);
    chk("ss_cnt", bus.snooze_cnt, 1);
    boundaries(9);
    chk("ss_idle_no_start", bus.alarm_start, 0);

    // Digit rules on slot 3
    inc(3, 3, 1);
    inc(3, 2, 9);
    chk("d_1900", dsp(), 16'h1900);
    inc(3, 3, 1);
    chk("d_hr10_clamp", dsp(), 16'h2000);
    inc(3, 2, 3);
    chk("d_2300", dsp(), 16'h2300);
    inc(3, 2, 1);
    chk("d_hr_wrap3", dsp(), 16'h2000);
    inc(3, 1, 5);
    chk("d_2050", dsp(), 16'h2050);
    inc(3, 1, 1);
    chk("d_min10_wrap", dsp(), 16'h2000);
    inc(3, 0, 9);
    chk("d_2009", dsp(), 16'h2009);
    inc(3, 0, 1);
    chk("d_min_wrap", dsp(), 16'h2000);
    inc(3, 3, 1);
    chk("d_hr10_wrap", dsp(), 16'h0000);

    // Disarming the ringing slot
    bus.arm = 4'b1000;
    tick_at(0, 0, 0, 0, 0, 0);
    chk("dis_ring", bus.ringing,  1);
    chk("dis_idx",  bus.ring_idx, 3);
    bus.arm = 4'b0000;
    cyc();
    chk("dis_off", bus.ringing, 0);

    // Reset during SNOOZE
    bus.arm = 4'b1000;
    tick_at(0, 0, 0, 0, 0, 0);
    pulse(1, 0);
    chk("rs_cnt1", bus.snooze_cnt, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rs_alarm_start", bus.alarm_start, 0);
    chk("rs_ringing",     bus.ringing,     0);
    chk("rs_ring_idx",    bus.ring_idx,    0);
    chk("rs_snooze_cnt",  bus.snooze_cnt,  0);
    bus.sel = 2'd1;
    cyc();
    chk("rs_slot1_clear", dsp(), 16'h0000);
    boundaries(9);
    chk("rs_idle_no_start", bus.alarm_start, 0);
    chk("rs_idle_no_ring",  bus.ringing,     0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
